serial_add_seq: RTL

SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

---
 rtl/serial_add_pkg.sv | 12 +
 rtl/serial_add_cnt.sv | 31 +++
 rtl/serial_add_seq.sv | 122 ++++++++++++
 3 files changed

// File: rtl/serial_add_pkg.sv
// Shared state encoding and default operand width for the bit-serial adder.
package serial_add_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_add_cnt.sv
// Bit counter for the serial adder: synchronous clear, increment, and a flag
// that marks the cycle in which the most significant bit is being added.
module serial_add_cnt
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial adder driving an external one-bit full adder, LSB first.
// Define SERIAL_ADD_OVF_EN to compute the signed overflow flag; otherwise ovf_o is tied low.
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             cin_i,
  output logic             fa_a_o,
  output logic             fa_b_o,
  output logic             fa_cin_o,
  input  logic             fa_sum_i,
  input  logic             fa_carry_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             cout_o,
  output logic             ovf_o
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_shift;
  logic             carry_reg, cout_reg;
  logic             accept, shifting, cnt_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    in_ready_o  = 1'b0;
    out_valid_o = 1'b0;
    fa_a_o      = 1'b0;
    fa_b_o      = 1'b0;
    fa_cin_o    = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready_o = 1'b1;
        if (in_valid_i) state_nxt = SHIFT;
      end
      SHIFT: begin
        fa_a_o   = a_sr[0];
        fa_b_o   = b_sr[0];
        fa_cin_o = carry_reg;
        if (cnt_last) state_nxt = HOLD;
      end
      HOLD: begin
        out_valid_o = 1'b1;
        if (out_ready_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign accept   = in_ready_o && in_valid_i;
  assign shifting = (state == SHIFT);

  // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  assign res_shift = (res_sr >> 1) | (WIDTH'(fa_sum_i) << (WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr      <= '0;
      b_sr      <= '0;
      res_sr    <= '0;
      carry_reg <= 1'b0;
      cout_reg  <= 1'b0;
    end else if (accept) begin
      a_sr      <= op_a_i;
      b_sr      <= op_b_i;
      carry_reg <= cin_i;
    end else if (shifting) begin
      a_sr      <= a_sr >> 1;
      b_sr      <= b_sr >> 1;
      res_sr    <= res_shift;
      carry_reg <= fa_carry_i;
      if (cnt_last) cout_reg <= fa_carry_i;
    end
  end

  serial_add_cnt #(
    .WIDTH (WIDTH)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (accept),
    .inc   (shifting),
    .last  (cnt_last)
  );

  assign result_o = res_sr;
  assign cout_o   = cout_reg;

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_reg;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_reg <= 1'b0;
    end else if (shifting && cnt_last) begin
      ovf_reg <= fa_cin_o ^ fa_carry_i;
    end
  end

  assign ovf_o = ovf_reg;
`else
  assign ovf_o = 1'b0;
`endif

endmodule
